uart_rx: RTL and testbench

//  8N1 UART receiver; downstream peer of uart_tx (its rx input is uart_tx's tx line).

---
 rtl/uart_rx_pkg.sv | 18 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_rx.sv | 166 ++++++++++++++++
 tb/tb_uart_rx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: definitions shared by the UART receiver (and its uart_tx peer):
// the receiver state encodings and the default bit period.
// Optional feature macro used by the receiver: UART_RX_PARITY_EN (8E1 framing).
package uart_rx_pkg;

    // 50 MHz / 115200 baud, rounded down.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for the asynchronous serial line.
// Both flops preset to 1 (line idle level) so reset never looks like a start bit.
module uart_sync2 (
    input  logic clk_50M,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input, preset to idle-high on reset.
    always_ff @(posedge clk_50M) begin
        // NOTE: sequential state uses non-blocking assignments so both stages
        // update from pre-edge values; blocking here would collapse the chain.
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling and one-cycle strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe;
// without it the PARITY state is never entered and parity_err is tied 0.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       parity_err
);

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'((CLKS_PER_BIT - 1) / 2);

    logic          rx_s;
    state_t        state, state_next;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          at_last;
    logic          shift_bit;
    logic          load_data;
    logic          done_next;
    logic          ferr_next;
    logic          suppress;

    uart_sync2 u_sync (
        .clk_50M (clk_50M),
        .rst     (rst),
        .d       (rx),
        .q       (rx_s)
    );

    assign at_last = (clk_cnt == LAST);
    assign rx_busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
    logic perr_next;
    logic par_bad;

    // Remember a parity failure so the stop bit is consumed without a second strobe.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            par_bad    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr_next;
            if (state == IDLE)
                par_bad <= 1'b0;
            else if (perr_next)
                par_bad <= 1'b1;
        end
    end

    assign suppress = par_bad;
`else
    assign parity_err = 1'b0;
    assign suppress   = 1'b0;
`endif

    // Next-state and strobe decode from the current state, bit timer and rx_s.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned, which would infer a latch.
        state_next = state;
        shift_bit  = 1'b0;
        load_data  = 1'b0;
        done_next  = 1'b0;
        ferr_next  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_next  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s)
                    state_next = START;
            end
            START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (clk_cnt == MID)
                    state_next = rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (at_last) begin
                    shift_bit = 1'b1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (at_last) begin
                    perr_next  = ((^shreg) != rx_s);
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                // Stop is sampled at mid-bit, leaving half a bit to catch a following start.
                if (at_last) begin
                    if (rx_s) begin
                        state_next = IDLE;
                        done_next  = !suppress;
                        load_data  = !suppress;
                    end else begin
                        state_next = BREAK;
                        ferr_next  = !suppress;
                    end
                end
            end
            BREAK: begin
                if (rx_s)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register, bit timer, bit index, shift register and output strobes.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            rx_done   <= done_next;
            frame_err <= ferr_next;

            // Timer restarts on every state change and wraps each bit period.
            if (state_next != state || at_last)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;

            if (state == IDLE)
                bit_idx <= 3'd0;
            else if (shift_bit)
                bit_idx <= bit_idx + 3'd1;

            if (shift_bit)
                shreg[bit_idx] <= rx_s;

            if (load_data)
                data <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx at CLKS_PER_BIT=16.
// Serial frames are driven by tasks; expected strobes go into a scoreboard
// queue and are popped by a monitor whenever the DUT pulses a strobe.
module tb_uart_rx;

    localparam int N = 16;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 2 + (N - 1) / 2 + 10 * N;
`else
    localparam int LAT = 2 + (N - 1) / 2 + 9 * N;
`endif

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic       rx      = 1'b1;
    logic [7:0] data;
    logic       rx_done;
    logic       rx_busy;
    logic       frame_err;
    logic       parity_err;

    typedef enum {EV_DONE, EV_FERR, EV_PERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [7:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  last_done_cyc = -1;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .rx         (rx),
        .data       (data),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    always #5 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cyc <= cyc + 1;

    // Scoreboard monitor: every strobe must match the head of the expected queue.
    always @(negedge clk_50M) begin
        ev_kind_t k;
        ev_t      e;
        logic     got;
        got = 1'b0;
        k   = EV_DONE;
        if (rx_done) begin
            k = EV_DONE; got = 1'b1; last_done_cyc = cyc;
        end else if (frame_err) begin
            k = EV_FERR; got = 1'b1;
        end else if (parity_err) begin
            k = EV_PERR; got = 1'b1;
        end
        if (got) begin
            total++;
            if (int'(rx_done) + int'(frame_err) + int'(parity_err) > 1) begin
                bad++;
                $display("FAIL strobe_exclusive: done=%b ferr=%b perr=%b, required at most one",
                         rx_done, frame_err, parity_err);
            end else if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe: got %s data=%h, required no strobe", k.name(), data);
            end else begin
                e = exp_q.pop_front();
                if (k != e.kind || data !== e.data) begin
                    bad++;
                    $display("FAIL strobe_match: got %s data=%h, required %s data=%h",
                             k.name(), data, e.kind.name(), e.data);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_50M);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        tick(N);
    endtask

    task automatic push(input ev_kind_t k, input logic [7:0] d);
        ev_t e;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Full frame: start, 8 data LSB first, [even parity, optionally flipped], stop.
    task automatic send_byte(input logic [7:0] b, input logic stop, input logic par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ par_flip);
`else
        if (par_flip) $display("note: parity flip has no effect in 8N1 build");
`endif
        drive_bit(stop);
    endtask

    // Bounded wait for every expected strobe to have been seen.
    task automatic drain(input string name);
        for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) tick(1);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d expected strobes not seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        check_val("reset_data", data, 8'h00);
        check_val("reset_rx_done", {7'd0, rx_done}, 8'h00);
        check_val("reset_rx_busy", {7'd0, rx_busy}, 8'h00);
        check_val("reset_frame_err", {7'd0, frame_err}, 8'h00);
        check_val("reset_parity_err", {7'd0, parity_err}, 8'h00);
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_single();
        int t0;
        push(EV_DONE, 8'hF0);
        t0 = cyc;
        fork
            send_byte(8'hF0, 1'b1, 1'b0);
            begin
                tick(4 * N);
                check_val("single_busy_mid", {7'd0, rx_busy}, 8'h01);
            end
        join
        check_val("single_busy_after_stop", {7'd0, rx_busy}, 8'h00);
        drain("single");
        check_val("single_data", data, 8'hF0);
        total++;
        if (last_done_cyc - t0 < LAT - 2 || last_done_cyc - t0 > LAT + 2) begin
            bad++;
            $display("FAIL single_latency: got %0d clocks, required %0d +/-2", last_done_cyc - t0, LAT);
        end
    endtask

    task automatic test_back_to_back();
        push(EV_DONE, 8'h55);
        push(EV_DONE, 8'hA5);
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'hA5, 1'b1, 1'b0);
        tick(N);
        drain("b2b");
        check_val("b2b_data", data, 8'hA5);
    endtask

    task automatic test_glitch();
        bit idle;
        rx = 1'b0;
        tick(4);
        check_val("glitch_busy_during", {7'd0, rx_busy}, 8'h01);
        rx = 1'b1;
        idle = 1'b0;
        for (int i = 0; i < 10 && !idle; i++) begin
            tick(1);
            idle = !rx_busy;
        end
        total++;
        if (!idle) begin
            bad++;
            $display("FAIL glitch_busy_return: busy=%b after 10 clocks, required 0", rx_busy);
        end
        tick(2 * N);
        drain("glitch");
        check_val("glitch_data", data, 8'hA5);
    endtask

    task automatic test_frame_err();
        push(EV_DONE, 8'h11);
        send_byte(8'h11, 1'b1, 1'b0);
        tick(N);
        drain("ferr_pre");
        push(EV_FERR, 8'h11);
        send_byte(8'h3C, 1'b0, 1'b0);
        tick(3 * N);
        check_val("ferr_busy_break", {7'd0, rx_busy}, 8'h01);
        check_val("ferr_data_held", data, 8'h11);
        rx = 1'b1;
        tick(4);
        check_val("ferr_busy_release", {7'd0, rx_busy}, 8'h00);
        drain("ferr");
        push(EV_DONE, 8'h7E);
        send_byte(8'h7E, 1'b1, 1'b0);
        tick(N);
        drain("ferr_post");
        check_val("ferr_post_data", data, 8'h7E);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b;
        b = 8'hC3;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rx = b[4];
        tick(N / 2);
        rst = 1'b1;
        rx  = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        check_val("rstmid_data", data, 8'h00);
        check_val("rstmid_busy", {7'd0, rx_busy}, 8'h00);
        check_val("rstmid_done", {7'd0, rx_done}, 8'h00);
        tick(2 * N);
        push(EV_DONE, 8'h81);
        send_byte(8'h81, 1'b1, 1'b0);
        tick(N);
        drain("rstmid_post");
        check_val("rstmid_post_data", data, 8'h81);
`ifdef UART_RX_PARITY_EN
        push(EV_PERR, 8'h81);
        send_byte(8'h81, 1'b1, 1'b1);
        tick(N);
        drain("parity_bad");
        check_val("parity_bad_busy", {7'd0, rx_busy}, 8'h00);
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid();
        tick(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
